mul_issue_ctrl: RTL and testbench

Initiator side of the multicycle multiplier handshake (start / annul / ready), placed in the EX stage.
- Accepts a MULT/MULTU request from EX and latches its operands.
- Drives mymul, stalls the pipeline until the product is ready, then issues a one-cycle HI/LO write.
- On a pipeline flush it cancels the operation safely and drains the multiplier so no stale result can be mistaken for a new one.

---
 rtl/mul_issue_ctrl_pkg.sv | 16 +
 rtl/mul_issue_ctrl.sv | 144 ++++++++++++++
 tb/tb_mul_issue_ctrl.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mul_issue_ctrl_pkg.sv
// Shared state encodings and handshake constants for the multiplier issue controller.
package mul_issue_ctrl_pkg;

  typedef enum logic [1:0] {
    MulCtlIdle  = 2'd0,
    MulCtlBusy  = 2'd1,
    MulCtlDone  = 2'd2,
    MulCtlAbort = 2'd3
  } mul_ctl_state_e;

  localparam logic        MulStart       = 1'b1;
  localparam logic        MulStop        = 1'b0;
  localparam logic        MulResultReady = 1'b1;
  localparam logic [31:0] ZeroWord       = 32'h0000_0000;

endpackage

// File: rtl/mul_issue_ctrl.sv
// EX-stage initiator for the multicycle multiplier: latches operands, stalls until
// the product arrives, writes HI/LO for one cycle, and annuls/drains on a flush.
module mul_issue_ctrl
  import mul_issue_ctrl_pkg::*;
#(
  parameter int DRAIN_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_mul_req,
  input  logic        ex_signed,
  input  logic [31:0] ex_op1,
  input  logic [31:0] ex_op2,
  input  logic        flush,
  input  logic [63:0] mul_result,
  input  logic        mul_ready,
  output logic        mul_start,
  output logic        mul_annul,
  output logic        mul_signed,
  output logic [31:0] mul_op1,
  output logic [31:0] mul_op2,
  output logic        stall_req,
  output logic        hilo_we,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  localparam int CW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  mul_ctl_state_e r_state;
  mul_ctl_state_e w_state_nxt;
  logic [CW-1:0]  r_drain;
  logic [31:0]    r_op1;
  logic [31:0]    r_op2;
  logic           r_signed;
  logic [31:0]    r_hi;
  logic [31:0]    r_lo;

  logic w_accept;
  logic w_ready;
  logic w_mul_start;
  logic w_mul_annul;
  logic w_stall_req;
  logic w_hilo_we;

  assign w_accept = (r_state == MulCtlIdle) & ex_mul_req & ~flush;
  assign w_ready  = (mul_ready == MulResultReady);

  // Next-state decode; flush outranks a same-cycle ready so a cancelled op never writes back.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      MulCtlIdle:  w_state_nxt = w_accept ? MulCtlBusy : MulCtlIdle;
      MulCtlBusy:  w_state_nxt = flush ? MulCtlAbort : (w_ready ? MulCtlDone : MulCtlBusy);
      MulCtlDone:  w_state_nxt = MulCtlIdle;
      MulCtlAbort: w_state_nxt = (r_drain == '0) ? MulCtlIdle : MulCtlAbort;
      default:     w_state_nxt = MulCtlIdle;
    endcase
  end

  // Output decode; the IDLE stall is gated by rst so reset forces every output low at once.
  always_comb begin
    w_mul_start = MulStop;
    w_mul_annul = 1'b0;
    w_stall_req = 1'b0;
    w_hilo_we   = 1'b0;
    case (r_state)
      MulCtlIdle: begin
        w_stall_req = rst & ex_mul_req & ~flush;
      end
      MulCtlBusy: begin
        w_mul_start = flush ? MulStop : MulStart;
        w_mul_annul = flush;
        w_stall_req = 1'b1;
      end
      MulCtlDone: begin
        w_hilo_we = ~flush;
      end
      MulCtlAbort: begin
        w_stall_req = 1'b0;
      end
      default: begin
        w_mul_start = MulStop;
      end
    endcase
  end

  // State, operand latch, product capture and drain counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= MulCtlIdle;
      r_drain  <= '0;
      r_op1    <= ZeroWord;
      r_op2    <= ZeroWord;
      r_signed <= 1'b0;
      r_hi     <= ZeroWord;
      r_lo     <= ZeroWord;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_op1    <= ex_op1;
        r_op2    <= ex_op2;
        r_signed <= ex_signed;
      end else begin
        r_op1    <= r_op1;
        r_op2    <= r_op2;
        r_signed <= r_signed;
      end
      case (r_state)
        MulCtlBusy: begin
          if (flush) begin
            r_drain <= CW'(DRAIN_CYCLES - 1);
          end else if (w_ready) begin
            r_hi <= mul_result[63:32];
            r_lo <= mul_result[31:0];
          end else begin
            r_drain <= r_drain;
          end
        end
        MulCtlAbort: begin
          if (r_drain != '0) begin
            r_drain <= r_drain - CW'(1);
          end else begin
            r_drain <= r_drain;
          end
        end
        default: begin
          r_drain <= r_drain;
        end
      endcase
    end
  end

  assign mul_start  = w_mul_start;
  assign mul_annul  = w_mul_annul;
  assign stall_req  = w_stall_req;
  assign hilo_we    = w_hilo_we;
  assign mul_signed = r_signed;
  assign mul_op1    = r_op1;
  assign mul_op2    = r_op2;
  assign hi_o       = r_hi;
  assign lo_o       = r_lo;

endmodule

// File: tb/tb_mul_issue_ctrl.sv
// Self-checking bench for mul_issue_ctrl: directed table, hand sequences, and random
// stimulus compared every cycle against a transaction-level reference model.
module tb_mul_issue_ctrl;

  localparam int DRAIN = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_mul_req, ex_signed, flush, mul_ready;
  logic [31:0] ex_op1, ex_op2;
  logic [63:0] mul_result;
  logic        mul_start, mul_annul, mul_signed, stall_req, hilo_we;
  logic [31:0] mul_op1, mul_op2, hi_o, lo_o;

  int n_vec = 0;
  int n_err = 0;

  mul_issue_ctrl #(.DRAIN_CYCLES(DRAIN)) dut (
    .clk(clk), .rst(rst), .ex_mul_req(ex_mul_req), .ex_signed(ex_signed),
    .ex_op1(ex_op1), .ex_op2(ex_op2), .flush(flush), .mul_result(mul_result),
    .mul_ready(mul_ready), .mul_start(mul_start), .mul_annul(mul_annul),
    .mul_signed(mul_signed), .mul_op1(mul_op1), .mul_op2(mul_op2),
    .stall_req(stall_req), .hilo_we(hilo_we), .hi_o(hi_o), .lo_o(lo_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        sgn;
    logic [31:0] op1;
    logic [31:0] op2;
    int          lat;
    int          flush_at;
    logic        exp_we;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
  } vec_t;

  // Reference model: an operation in flight, a pending write-back, cycles of drain left.
  bit          m_busy, m_done;
  int          m_drain;
  logic        m_sgn;
  logic [31:0] m_op1, m_op2, m_hi, m_lo;

  function automatic logic [63:0] prod(input logic s, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      return 64'(sa * sb);
    end else begin
      return {32'h0, a} * {32'h0, b};
    end
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_done = 0; m_drain = 0;
    m_sgn = 1'b0; m_op1 = 32'h0; m_op2 = 32'h0; m_hi = 32'h0; m_lo = 32'h0;
  endtask

  task automatic model_check();
    bit idle;
    idle = !m_busy && !m_done && (m_drain == 0);
    chk("m_start",  {63'h0, mul_start}, {63'h0, m_busy && !flush});
    chk("m_annul",  {63'h0, mul_annul}, {63'h0, m_busy && flush});
    chk("m_stall",  {63'h0, stall_req}, {63'h0, m_busy || (idle && ex_mul_req && !flush)});
    chk("m_hilowe", {63'h0, hilo_we},   {63'h0, m_done && !flush});
    chk("m_signed", {63'h0, mul_signed}, {63'h0, m_sgn});
    chk("m_op1",    {32'h0, mul_op1},   {32'h0, m_op1});
    chk("m_op2",    {32'h0, mul_op2},   {32'h0, m_op2});
    chk("m_hi",     {32'h0, hi_o},      {32'h0, m_hi});
    chk("m_lo",     {32'h0, lo_o},      {32'h0, m_lo});
  endtask

  task automatic model_step();
    bit idle;
    logic [63:0] r;
    idle = !m_busy && !m_done && (m_drain == 0);
    if (m_drain > 0) m_drain--;
    if (m_done) begin
      m_done = 0;
    end else if (m_busy) begin
      if (flush) begin
        m_busy = 0;
        m_drain = DRAIN;
      end else if (mul_ready) begin
        r = mul_result;
        m_hi = r[63:32];
        m_lo = r[31:0];
        m_busy = 0;
        m_done = 1;
      end
    end else if (idle && ex_mul_req && !flush) begin
      m_op1 = ex_op1; m_op2 = ex_op2; m_sgn = ex_signed;
      m_busy = 1;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    model_check();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_start"},  {63'h0, mul_start}, 64'h0);
    chk({tag, "_annul"},  {63'h0, mul_annul}, 64'h0);
    chk({tag, "_stall"},  {63'h0, stall_req}, 64'h0);
    chk({tag, "_hilowe"}, {63'h0, hilo_we},   64'h0);
    chk({tag, "_signed"}, {63'h0, mul_signed}, 64'h0);
    chk({tag, "_ops"},    {mul_op1, mul_op2}, 64'h0);
    chk({tag, "_hilo"},   {hi_o, lo_o},       64'h0);
  endtask

  // Issue one request, run the handshake, then check the write-back (or its absence).
  task automatic run_op(input vec_t v);
    bit ended = 0;
    ex_mul_req = 1'b1; ex_signed = v.sgn; ex_op1 = v.op1; ex_op2 = v.op2;
    flush = 1'b0; mul_ready = 1'b0;
    #1;
    chk("req_stall", {63'h0, stall_req}, 64'h1);
    chk("req_nostart", {63'h0, mul_start}, 64'h0);
    tick();
    ex_op1 = ~v.op1;
    for (int k = 1; k <= 64 && !ended; k++) begin
      mul_ready  = (k == v.lat);
      mul_result = prod(v.sgn, v.op1, v.op2);
      flush      = (k == v.flush_at);
      #1;
      chk("busy_start", {63'h0, mul_start}, {63'h0, !flush});
      chk("busy_stall", {63'h0, stall_req}, 64'h1);
      chk("busy_op1",   {32'h0, mul_op1},   {32'h0, v.op1});
      tick();
      ended = flush || mul_ready;
    end
    if (!ended) chk("busy_timeout", 64'h0, 64'h1);
    mul_ready = 1'b0; flush = 1'b0; ex_op1 = v.op1;
    #1;
    chk("wb_we",    {63'h0, hilo_we},   {63'h0, v.exp_we});
    chk("wb_stall", {63'h0, stall_req}, 64'h0);
    chk("wb_start", {63'h0, mul_start}, 64'h0);
    if (v.exp_we) chk("wb_hilo", {hi_o, lo_o}, {v.exp_hi, v.exp_lo});
    tick();
    ex_mul_req = 1'b0;
    repeat (DRAIN) tick();
  endtask

  vec_t tbl[8];

  initial begin
    tbl[0] = '{1'b1, 32'hFFFF_FFFE, 32'h0000_0003, 4, 0,  1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFA};
    tbl[1] = '{1'b0, 32'hFFFF_FFFF, 32'h0000_0002, 4, 0,  1'b1, 32'h0000_0001, 32'hFFFF_FFFE};
    tbl[2] = '{1'b0, 32'h0000_0000, 32'h0000_0005, 1, 0,  1'b1, 32'h0000_0000, 32'h0000_0000};
    tbl[3] = '{1'b1, 32'h0000_0007, 32'hFFFF_FFFF, 3, 0,  1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFF9};
    tbl[4] = '{1'b1, 32'h8000_0000, 32'h8000_0000, 5, 0,  1'b1, 32'h4000_0000, 32'h0000_0000};
    tbl[5] = '{1'b0, 32'h1234_5678, 32'h0000_0010, 2, 0,  1'b1, 32'h0000_0001, 32'h2345_6780};
    tbl[6] = '{1'b1, 32'h0000_0009, 32'h0000_0009, 20, 10, 1'b0, 32'h0, 32'h0};
    tbl[7] = '{1'b0, 32'h0000_0003, 32'h0000_0004, 3, 3,  1'b0, 32'h0, 32'h0};

    rst = 1'b0; ex_mul_req = 1'b1; ex_signed = 1'b1; ex_op1 = 32'h1; ex_op2 = 32'h2;
    flush = 1'b0; mul_ready = 1'b1; mul_result = 64'hDEAD_BEEF_0000_0001;
    model_reset();
    #2;
    check_all_zero("reset");
    @(negedge clk);
    ex_mul_req = 1'b0; mul_ready = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) run_op(tbl[i]);

    // Flush at BUSY cycle 10 with a new request held through the drain window.
    ex_mul_req = 1'b1; ex_signed = 1'b0; ex_op1 = 32'h0000_0011; ex_op2 = 32'h0000_0013;
    tick();
    for (int k = 1; k < 10; k++) tick();
    flush = 1'b1;
    #1;
    chk("fl_annul", {63'h0, mul_annul}, 64'h1);
    chk("fl_start", {63'h0, mul_start}, 64'h0);
    tick();
    flush = 1'b0; ex_op1 = 32'h0000_0006; ex_op2 = 32'h0000_0007;
    for (int k = 0; k < DRAIN; k++) begin
      #1;
      chk("drain_stall", {63'h0, stall_req}, 64'h0);
      chk("drain_start", {63'h0, mul_start}, 64'h0);
      chk("drain_annul", {63'h0, mul_annul}, 64'h0);
      chk("drain_we",    {63'h0, hilo_we},   64'h0);
      tick();
    end
    #1;
    chk("reissue_stall", {63'h0, stall_req}, 64'h1);
    tick();
    chk("reissue_start", {63'h0, mul_start}, 64'h1);
    chk("reissue_op",    {mul_op1, mul_op2}, {32'h6, 32'h7});
    tick();
    mul_ready = 1'b1; mul_result = prod(1'b0, 32'h6, 32'h7);
    tick();
    mul_ready = 1'b0;
    #1;
    chk("reissue_we",   {63'h0, hilo_we}, 64'h1);
    chk("reissue_hilo", {hi_o, lo_o}, 64'h0000_0000_0000_002A);
    tick();
    ex_mul_req = 1'b0;
    repeat (DRAIN) tick();

    // Back-to-back: next request right after DONE starts at ready+2.
    ex_mul_req = 1'b1; ex_signed = 1'b1; ex_op1 = 32'h5; ex_op2 = 32'hFFFF_FFFD;
    tick(); tick();
    mul_ready = 1'b1; mul_result = prod(1'b1, 32'h5, 32'hFFFF_FFFD);
    tick();
    mul_ready = 1'b0;
    tick();
    #1;
    chk("b2b_stall", {63'h0, stall_req}, 64'h1);
    tick();
    chk("b2b_start", {63'h0, mul_start}, 64'h1);

    // Asynchronous reset mid-BUSY.
    #2;
    rst = 1'b0;
    #1;
    check_all_zero("async_rst");
    model_reset();
    @(negedge clk);
    ex_mul_req = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    run_op(tbl[0]);

    // Randomized traffic against the reference model.
    for (int c = 0; c < 600; c++) begin
      ex_mul_req = ($urandom_range(0, 99) < 70);
      flush      = ($urandom_range(0, 99) < 8);
      mul_ready  = ($urandom_range(0, 99) < 35);
      ex_signed  = 1'($urandom_range(0, 1));
      ex_op1     = $urandom;
      ex_op2     = $urandom;
      mul_result = {$urandom, $urandom};
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
